// File: rtl/npu_axi_rd_arbiter_if.sv
// AXI read address/data channel bundle shared by requesters and master.
// The slave view is the arbiter's side of a requester link.
interface npu_axi_rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 256
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, rready,
    input  arready, rvalid, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, rready,
    output arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/npu_axi_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin grant, one burst in flight,
// R channel steered to the granted requester, sticky burst-length check.
module npu_axi_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  npu_axi_rd_arbiter_if.slave   s0,
  npu_axi_rd_arbiter_if.slave   s1,
  npu_axi_rd_arbiter_if.master  m_axi,
  output logic                  grant_id,
  output logic                  busy,
  output logic                  len_err,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic              r_grant_id;
  logic              r_arvalid;
  logic              r_len_err;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arsize;
  logic [8:0]        r_cnt;

  logic              w_req;
  logic              w_win;
  logic              w_ar_hs;
  logic              w_m_ar_hs;
  logic              w_g0;
  logic              w_g1;
  logic              w_r_hs;
  logic              w_len_set;
  logic [7:0]        w_sel_len;
  logic [DATA_W-1:0] w_rdata;

  // Tie goes to whoever was not served last; a lone request always wins.
  assign w_req     = s0.arvalid | s1.arvalid;
  assign w_win     = (s0.arvalid & s1.arvalid) ? ~r_last_grant : s1.arvalid;
  assign w_ar_hs   = (r_state == IDLE) & w_req;
  assign w_m_ar_hs = (r_state == ADDR) & r_arvalid & m_axi.arready;
  assign w_g0      = (r_state == DATA) & ~r_grant_id;
  assign w_g1      = (r_state == DATA) & r_grant_id;
  assign w_r_hs    = (r_state == DATA) & m_axi.rvalid & m_axi.rready;
  assign w_sel_len = w_win ? s1.arlen : s0.arlen;
  assign w_rdata   = m_axi.rdata;

  assign w_len_set = w_r_hs &
    (m_axi.rlast ? (r_cnt != 9'd1) : (r_cnt == 9'd1));

  assign s0.arready = w_ar_hs & ~w_win;
  assign s1.arready = w_ar_hs & w_win;

  assign s0.rvalid = w_g0 & m_axi.rvalid;
  assign s1.rvalid = w_g1 & m_axi.rvalid;
  assign s0.rdata  = w_g0 ? w_rdata : '0;
  assign s1.rdata  = w_g1 ? w_rdata : '0;
  assign s0.rlast  = w_g0 & m_axi.rlast;
  assign s1.rlast  = w_g1 & m_axi.rlast;

  assign m_axi.rready  = (w_g0 & s0.rready) | (w_g1 & s1.rready);
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arlen   = r_arlen;
  assign m_axi.arsize  = r_arsize;

  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);
  assign len_err  = r_len_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_ar_hs) w_next = ADDR;
      ADDR:    if (w_m_ar_hs) w_next = DATA;
      DATA:    if (w_r_hs && m_axi.rlast) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_cnt        <= '0;
      r_len_err    <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_araddr   <= w_win ? s1.araddr : s0.araddr;
        r_arlen    <= w_sel_len;
        r_arsize   <= w_win ? s1.arsize : s0.arsize;
        r_grant_id <= w_win;
        r_cnt      <= {1'b0, w_sel_len} + 9'd1;
        r_arvalid  <= 1'b1;
      end else if (w_m_ar_hs) begin
        r_arvalid  <= 1'b0;
      end
      // Counter parks at zero if the slave overruns the burst.
      if (w_r_hs) begin
        if (r_cnt != 9'd0) r_cnt <= r_cnt - 9'd1;
        if (m_axi.rlast) r_last_grant <= r_grant_id;
      end
      if (w_len_set)    r_len_err <= 1'b1;
      else if (err_clr) r_len_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_npu_axi_rd_arbiter.sv
// Directed bench for npu_axi_rd_arbiter: single burst, ties,
// backpressure, length errors and mid-burst reset.
module tb_npu_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic grant_id;
  logic busy;
  logic len_err;
  logic err_clr;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   exp_w [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int   beat;

  npu_axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(256)) s0_if ();
  npu_axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(256)) s1_if ();
  npu_axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(256)) m_if ();

  npu_axi_rd_arbiter #(.ADDR_W(64), .DATA_W(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0       (s0_if),
    .s1       (s1_if),
    .m_axi    (m_if),
    .grant_id (grant_id),
    .busy     (busy),
    .len_err  (len_err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lone request from one side, AR accepted by the master at once.
  task automatic issue(input bit sel, input logic [63:0] addr,
                       input logic [7:0] len);
    if (sel) begin
      s1_if.arvalid = 1'b1; s1_if.araddr = addr; s1_if.arlen = len;
    end else begin
      s0_if.arvalid = 1'b1; s0_if.araddr = addr; s0_if.arlen = len;
    end
    #1;
    chk("ar_ready", sel ? s1_if.arready : s0_if.arready, 64'd1);
    tick();
    s0_if.arvalid = 1'b0;
    s1_if.arvalid = 1'b0;
    chk("ar_grant", grant_id, {63'd0, sel});
    chk("ar_valid", m_if.arvalid, 64'd1);
    chk("ar_addr", m_if.araddr, addr);
    chk("ar_len", m_if.arlen, {56'd0, len});
    tick();
  endtask

  task automatic rbeat(input logic [31:0] d, input bit last);
    m_if.rvalid = 1'b1;
    m_if.rdata  = 256'(d);
    m_if.rlast  = last;
    tick();
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    s0_if.arvalid = 0; s0_if.araddr = 0; s0_if.arlen = 0;
    s0_if.arsize = 3'd5; s0_if.rready = 1'b1;
    s1_if.arvalid = 0; s1_if.araddr = 0; s1_if.arlen = 0;
    s1_if.arsize = 3'd5; s1_if.rready = 1'b1;
    m_if.arready = 1'b1; m_if.rvalid = 0; m_if.rdata = '0;
    m_if.rlast = 0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_busy", busy, 64'd0);
    chk("rst_grant", grant_id, 64'd0);
    chk("rst_lenerr", len_err, 64'd0);
    chk("rst_arvalid", m_if.arvalid, 64'd0);
    chk("rst_araddr", m_if.araddr, 64'd0);
    chk("rst_arlen", m_if.arlen, 64'd0);
    chk("rst_rready", m_if.rready, 64'd0);

    // Single s1 burst of 4 beats
    issue(1'b1, 64'h1000, 8'd3);
    chk("s1_arvalid_lo", m_if.arvalid, 64'd0);
    chk("s1_busy", busy, 64'd1);
    for (int i = 0; i < 4; i++) begin
      m_if.rvalid = 1'b1;
      m_if.rdata  = 256'(32'hA0 + i);
      m_if.rlast  = (i == 3);
      #1;
      chk("s1_rvalid", s1_if.rvalid, 64'd1);
      chk("s1_rdata", s1_if.rdata[63:0], 64'(32'hA0 + i));
      chk("s0_rvalid_lo", s0_if.rvalid, 64'd0);
      chk("s1_mrready", m_if.rready, 64'd1);
      tick();
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    chk("s1_done_busy", busy, 64'd0);
    chk("s1_done_err", len_err, 64'd0);

    // Repeated ties right after reset alternate 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    s0_if.araddr = 64'h100; s0_if.arlen = 8'd0; s0_if.arvalid = 1'b1;
    s1_if.araddr = 64'h200; s1_if.arlen = 8'd0; s1_if.arvalid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("tie_rdy0", s0_if.arready, {63'd0, ~exp_w[i]});
      chk("tie_rdy1", s1_if.arready, {63'd0, exp_w[i]});
      tick();
      chk("tie_grant", grant_id, {63'd0, exp_w[i]});
      chk("tie_addr", m_if.araddr, exp_w[i] ? 64'h200 : 64'h100);
      chk("tie_wait0", s0_if.arready, 64'd0);
      chk("tie_wait1", s1_if.arready, 64'd0);
      tick();
      m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
      #1;
      chk("tie_rv_g", exp_w[i] ? s1_if.rvalid : s0_if.rvalid, 64'd1);
      chk("tie_rv_n", exp_w[i] ? s0_if.rvalid : s1_if.rvalid, 64'd0);
      tick();
      m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    end
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
    tick();

    // AR backpressure then toggling rready on s0
    m_if.arready = 1'b0;
    s0_if.arvalid = 1'b1; s0_if.araddr = 64'hDEAD0;
    s0_if.arlen = 8'd2; s0_if.arsize = 3'd3;
    #1;
    chk("bp_ready", s0_if.arready, 64'd1);
    tick();
    s0_if.arvalid = 1'b0; s0_if.araddr = 64'hBAD; s0_if.arlen = 8'd9;
    s1_if.arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_arvalid", m_if.arvalid, 64'd1);
      chk("bp_araddr", m_if.araddr, 64'hDEAD0);
      chk("bp_arlen", m_if.arlen, 64'd2);
      chk("bp_arsize", m_if.arsize, 64'd3);
      chk("bp_s1_wait", s1_if.arready, 64'd0);
      tick();
    end
    s1_if.arvalid = 1'b0;
    m_if.arready = 1'b1;
    tick();
    chk("bp_arvalid_lo", m_if.arvalid, 64'd0);
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      s0_if.rready = c[0];
      m_if.rvalid  = 1'b1;
      m_if.rdata   = 256'(beat + 32'h50);
      m_if.rlast   = (beat == 2);
      #1;
      chk("bp_mrready", m_if.rready, {63'd0, c[0]});
      chk("bp_rdata", s0_if.rdata[63:0], 64'(beat + 32'h50));
      tick();
      if (c[0]) beat++;
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s0_if.rready = 1'b1;
    chk("bp_busy", busy, 64'd0);
    chk("bp_lenerr", len_err, 64'd0);
    tick();
    chk("bp_no_latch", busy, 64'd0);
    chk("bp_idle_arv", m_if.arvalid, 64'd0);

    // Early rlast sets len_err; clear; overrun with clear -> set wins
    issue(1'b1, 64'h2000, 8'd1);
    rbeat(32'h1, 1'b1);
    chk("le_set", len_err, 64'd1);
    chk("le_idle", busy, 64'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("le_clr", len_err, 64'd0);
    issue(1'b1, 64'h2100, 8'd0);
    rbeat(32'h2, 1'b0);
    chk("le_nonlast", len_err, 64'd1);
    chk("le_still_busy", busy, 64'd1);
    err_clr = 1'b1; tick();
    chk("le_clr2", len_err, 64'd0);
    rbeat(32'h3, 1'b1);
    err_clr = 1'b0;
    chk("le_set_wins", len_err, 64'd1);
    chk("le_end", busy, 64'd0);

    // Reset after 2 of 8 beats, with a beat still on the bus
    issue(1'b0, 64'h4000, 8'd7);
    rbeat(32'h10, 1'b0);
    rbeat(32'h11, 1'b0);
    chk("mr_busy_pre", busy, 64'd1);
    m_if.rvalid = 1'b1; m_if.rdata = 256'(32'h12);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_busy", busy, 64'd0);
    chk("mr_rready", m_if.rready, 64'd0);
    chk("mr_rv0", s0_if.rvalid, 64'd0);
    chk("mr_rv1", s1_if.rvalid, 64'd0);
    chk("mr_arvalid", m_if.arvalid, 64'd0);
    chk("mr_lenerr", len_err, 64'd0);
    chk("mr_grant", grant_id, 64'd0);
    tick();
    chk("mr_rv0_hold", s0_if.rvalid, 64'd0);
    m_if.rvalid = 1'b0;
    issue(1'b1, 64'h5000, 8'd0);
    m_if.rvalid = 1'b1; m_if.rdata = 256'(32'h77); m_if.rlast = 1'b1;
    #1;
    chk("mr_new_rv", s1_if.rvalid, 64'd1);
    chk("mr_new_rd", s1_if.rdata[63:0], 64'h77);
    tick();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    chk("mr_new_done", busy, 64'd0);
    chk("mr_new_err", len_err, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
